// File: rtl/unpacked_result_serializer.sv
// Snapshots two unpacked result arrays on start and streams them out interleaved
// (x0, y0, x1, y1, ...) over valid/ready, with a per-frame checksum and a dropped-start counter.
module unpacked_result_serializer #(
  parameter  int WIDTH = 32,
  parameter  int DEPTH = 4,
  parameter  int CNT_W = 8,
  localparam int LEN   = 2 * DEPTH,
  localparam int IDX_W = (LEN > 1) ? $clog2(LEN) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] result_x [0:DEPTH-1],
  input  logic [WIDTH-1:0] result_y [0:DEPTH-1],
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [IDX_W-1:0] out_idx,
  output logic             out_last,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] frame_sum,
  output logic [CNT_W-1:0] drop_cnt
);

  typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_e;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LEN - 1);

  state_e           state_q;
  logic [WIDTH-1:0] buf_q [0:LEN-1];
  logic [WIDTH-1:0] acc_q;
  logic [IDX_W-1:0] idx_d;
  logic             hs_s;
  logic             last_hs_s;
  logic             cap_s;

  assign hs_s      = out_valid && out_ready;
  assign last_hs_s = hs_s && out_last;
  // A start coinciding with the final handshake chains straight into the next frame.
  assign cap_s     = start && ((state_q == IDLE) || last_hs_s);
  assign idx_d     = out_idx + IDX_W'(1);
  assign busy      = (state_q == SEND);

  // Snapshot buffer: no reset needed, contents only matter after a capture.
  always_ff @(posedge clk) begin
    if (cap_s) begin
      for (int i = 0; i < DEPTH; i++) begin
        buf_q[2*i]   <= result_x[i];
        buf_q[2*i+1] <= result_y[i];
      end
    end
  end

  // Control FSM with registered stream outputs, checksum and drop counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_idx   <= '0;
      out_last  <= 1'b0;
      done      <= 1'b0;
      frame_sum <= '0;
      drop_cnt  <= '0;
      acc_q     <= '0;
    end else begin
      done <= 1'b0;
      if (start && busy && !last_hs_s && (drop_cnt != {CNT_W{1'b1}})) begin
        drop_cnt <= drop_cnt + CNT_W'(1);
      end
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q   <= SEND;
            out_valid <= 1'b1;
            out_data  <= result_x[0];
            out_idx   <= '0;
            out_last  <= 1'b0;
            acc_q     <= '0;
          end
        end
        SEND: begin
          if (hs_s) begin
            if (out_last) begin
              done      <= 1'b1;
              frame_sum <= acc_q + out_data;
              acc_q     <= '0;
              out_idx   <= '0;
              out_last  <= 1'b0;
              if (start) begin
                out_data <= result_x[0];
              end else begin
                state_q   <= IDLE;
                out_valid <= 1'b0;
              end
            end else begin
              acc_q    <= acc_q + out_data;
              out_idx  <= idx_d;
              out_data <= buf_q[idx_d];
              out_last <= (idx_d == LAST_IDX);
            end
          end
        end
        default: begin
          state_q   <= IDLE;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_unpacked_result_serializer.sv
// Directed bench for unpacked_result_serializer: a vector table for the basic and
// backpressured frames, plus hand-written multi-cycle sequences.
module tb_unpacked_result_serializer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        out_ready;
  logic [31:0] rx [0:3];
  logic [31:0] ry [0:3];
  logic        out_valid;
  logic [31:0] out_data;
  logic [2:0]  out_idx;
  logic        out_last;
  logic        busy;
  logic        done;
  logic [31:0] frame_sum;
  logic [7:0]  drop_cnt;

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] exp_w [0:7];

  typedef struct {
    logic        start;
    logic        ready;
    logic        valid;
    logic [31:0] data;
    logic [2:0]  idx;
    logic        last;
    logic        busy;
    logic        done;
    logic [31:0] sum;
    logic [7:0]  drop;
  } vec_t;

  vec_t vecs[$];

  unpacked_result_serializer #(.WIDTH(32), .DEPTH(4), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .result_x(rx), .result_y(ry),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_idx(out_idx), .out_last(out_last), .busy(busy), .done(done),
    .frame_sum(frame_sum), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL timeout: simulation did not reach the summary");
    $fatal(1);
  end

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endfunction

  function automatic void add(logic s, logic r, logic v, logic [31:0] d, int i,
                              logic l, logic b, logic dn, logic [31:0] sm, logic [7:0] dr);
    vec_t e;
    e.start = s; e.ready = r; e.valid = v; e.data = d; e.idx = 3'(i);
    e.last = l; e.busy = b; e.done = dn; e.sum = sm; e.drop = dr;
    vecs.push_back(e);
  endfunction

  task automatic set_basic();
    rx[0] = 32'h1112; rx[1] = 32'h3336; rx[2] = 32'h555A; rx[3] = 32'h777E;
    ry[0] = 32'h2220; ry[1] = 32'h4440; ry[2] = 32'h6660; ry[3] = 32'h8880;
    for (int i = 0; i < 4; i++) begin
      exp_w[2*i]   = rx[i];
      exp_w[2*i+1] = ry[i];
    end
  endtask

  task automatic set_all(input logic [31:0] v);
    for (int i = 0; i < 4; i++) begin
      rx[i] = v;
      ry[i] = v;
    end
  endtask

  // Called at a negedge right after start=1 was driven; checks words first_k..7 then the done cycle.
  task automatic stream(input int first_k, input int pa, input int pb, input bit corrupt,
                        input logic [31:0] esum, input logic [7:0] edrop);
    bit restart;
    for (int k = first_k; k < 8; k++) begin
      @(negedge clk);
      chk("word_valid", 32'(out_valid), 32'd1);
      chk("word_data", out_data, exp_w[k]);
      chk("word_idx", 32'(out_idx), 32'(k));
      chk("word_last", 32'(out_last), (k == 7) ? 32'd1 : 32'd0);
      chk("word_done", 32'(done), 32'd0);
      if (corrupt && k == first_k) set_all(32'hFFFF_FFFF);
      start = (k == pa) || (k == pb);
      out_ready = 1'b1;
    end
    @(negedge clk);
    restart = (pa == 7) || (pb == 7);
    chk("done_pulse", 32'(done), 32'd1);
    chk("frame_sum", frame_sum, esum);
    chk("drop_cnt", 32'(drop_cnt), 32'(edrop));
    chk("valid_after", 32'(out_valid), restart ? 32'd1 : 32'd0);
    if (restart) begin
      chk("restart_idx", 32'(out_idx), 32'd0);
      chk("restart_data", out_data, exp_w[0]);
    end
    start = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    out_ready = 1'b0;
    set_basic();

    // Basic frame, then the same frame with 3 cycles of backpressure on idx 2.
    add(1'b1, 1'b1, 1'b0, 32'h0, 0, 1'b0, 1'b0, 1'b0, 32'h0, 8'd0);
    for (int k = 0; k < 8; k++)
      add(1'b0, 1'b1, 1'b1, exp_w[k], k, k == 7, 1'b1, 1'b0, 32'h0, 8'd0);
    add(1'b0, 1'b1, 1'b0, 32'h0, 0, 1'b0, 1'b0, 1'b1, 32'h0002_6660, 8'd0);
    add(1'b1, 1'b1, 1'b0, 32'h0, 0, 1'b0, 1'b0, 1'b0, 32'h0002_6660, 8'd0);
    for (int k = 0; k < 8; k++) begin
      if (k == 2)
        for (int j = 0; j < 3; j++)
          add(1'b0, 1'b0, 1'b1, exp_w[k], k, 1'b0, 1'b1, 1'b0, 32'h0002_6660, 8'd0);
      add(1'b0, 1'b1, 1'b1, exp_w[k], k, k == 7, 1'b1, 1'b0, 32'h0002_6660, 8'd0);
    end
    add(1'b0, 1'b1, 1'b0, 32'h0, 0, 1'b0, 1'b0, 1'b1, 32'h0002_6660, 8'd0);

    @(negedge clk);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_data", out_data, 32'd0);
    chk("rst_sum", frame_sum, 32'd0);
    chk("rst_drop", 32'(drop_cnt), 32'd0);
    rst = 1'b0;

    foreach (vecs[i]) begin
      @(negedge clk);
      chk("tbl_valid", 32'(out_valid), 32'(vecs[i].valid));
      chk("tbl_busy", 32'(busy), 32'(vecs[i].busy));
      chk("tbl_done", 32'(done), 32'(vecs[i].done));
      chk("tbl_sum", frame_sum, vecs[i].sum);
      chk("tbl_drop", 32'(drop_cnt), 32'(vecs[i].drop));
      if (vecs[i].valid) begin
        chk("tbl_data", out_data, vecs[i].data);
        chk("tbl_idx", 32'(out_idx), 32'(vecs[i].idx));
        chk("tbl_last", 32'(out_last), 32'(vecs[i].last));
      end
      start = vecs[i].start;
      out_ready = vecs[i].ready;
    end

    // Snapshot isolation with two dropped starts mid-frame.
    @(negedge clk);
    start = 1'b1;
    out_ready = 1'b1;
    stream(0, 2, 4, 1'b1, 32'h0002_6660, 8'd2);
    @(negedge clk);
    chk("single_done", 32'(done), 32'd0);
    chk("drop_after_frame", 32'(drop_cnt), 32'd2);

    // Back-to-back: start on the last-word handshake.
    set_basic();
    start = 1'b1;
    stream(0, 7, -1, 1'b0, 32'h0002_6660, 8'd2);
    stream(1, -1, -1, 1'b0, 32'h0002_6660, 8'd2);

    // Checksum wrap.
    set_all(32'h8000_0000);
    for (int i = 0; i < 8; i++) exp_w[i] = 32'h8000_0000;
    start = 1'b1;
    stream(0, -1, -1, 1'b0, 32'h0000_0000, 8'd2);

    // Drop counter saturation while stalled on idx 0.
    start = 1'b1;
    out_ready = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (i == 100) chk("drop_mid", 32'(drop_cnt), 32'd102);
    end
    start = 1'b0;
    @(negedge clk);
    chk("drop_sat", 32'(drop_cnt), 32'hFF);
    chk("stall_valid", 32'(out_valid), 32'd1);
    chk("stall_idx", 32'(out_idx), 32'd0);

    // Asynchronous reset at idx 4.
    out_ready = 1'b1;
    repeat (4) @(negedge clk);
    chk("pre_rst_idx", 32'(out_idx), 32'd4);
    #2 rst = 1'b1;
    #1;
    chk("arst_valid", 32'(out_valid), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_idx", 32'(out_idx), 32'd0);
    chk("arst_drop", 32'(drop_cnt), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("arst_no_done", 32'(done), 32'd0);
    chk("arst_sum", frame_sum, 32'd0);
    set_basic();
    start = 1'b1;
    stream(0, -1, -1, 1'b0, 32'h0002_6660, 8'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
